// File: rtl/mul12_recompose_if.sv
// Operand/result handshake bundle for the quotient*radix+remainder recomposer.
interface mul12_recompose_if #(
  parameter int unsigned Q_W   = 3,
  parameter int unsigned R_W   = 4,
  parameter int unsigned OUT_W = 7
);

  logic             in_valid;
  logic             in_ready;
  logic [Q_W-1:0]   in_quot;
  logic [R_W-1:0]   in_rem;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_err;

  // Producer of operands and consumer of results.
  modport master (
    output in_valid,
    output in_quot,
    output in_rem,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_err
  );

  // The recomposer itself.
  modport slave (
    input  in_valid,
    input  in_quot,
    input  in_rem,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_err
  );

endinterface

// File: rtl/mul12_recompose.sv
// Rebuilds a flat index from {quotient, remainder}: out = quot*DIVISOR + rem.
// The multiply is serial shift-add, one quotient bit per clock, so no
// hardware multiplier is needed; arithmetic wraps modulo 2**OUT_W.
module mul12_recompose #(
  parameter int unsigned DIVISOR = 12,
  parameter int unsigned Q_W     = 3,
  parameter int unsigned R_W     = 4,
  parameter int unsigned OUT_W   = 7
) (
  input  logic               clk,
  input  logic               rst,
  mul12_recompose_if.slave   bus,
  output logic               busy
);

  localparam int unsigned CNT_W = (Q_W > 1) ? $clog2(Q_W) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [OUT_W-1:0]   acc_q,   acc_d;
  logic [Q_W-1:0]     q_sh_q,  q_sh_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic               err_q,   err_d;

  // Shifted divisor term for the current quotient bit position.
  logic [OUT_W-1:0]   addend;
  assign addend = OUT_W'(DIVISOR) << cnt_q;

  // State and datapath registers; reset clears any in-flight result.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      q_sh_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      q_sh_q  <= q_sh_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state and datapath update; registers hold unless a state acts.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    q_sh_d  = q_sh_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        // in_ready is high throughout IDLE, so in_valid alone accepts.
        if (bus.in_valid) begin
          acc_d   = OUT_W'(bus.in_rem);
          q_sh_d  = bus.in_quot;
          cnt_d   = '0;
          err_d   = (bus.in_rem >= R_W'(DIVISOR));
          state_d = CALC;
        end
      end
      CALC: begin
        if (q_sh_q[0]) begin
          acc_d = acc_q + addend;
        end
        q_sh_d = q_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        // Always spend exactly Q_W cycles here, even for a zero quotient.
        if (cnt_q == CNT_W'(Q_W - 1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Accumulator is frozen here, keeping out_data/out_err stable.
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Handshake flags decode from the state register only.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign busy          = (state_q != IDLE);
  assign bus.out_data  = acc_q;
  assign bus.out_err   = err_q;

endmodule

// File: tb/tb_mul12_recompose.sv
// Randomized self-checking bench for mul12_recompose against an arithmetic model.
module tb_mul12_recompose;

  localparam int unsigned DIVISOR = 12;
  localparam int unsigned Q_W     = 3;
  localparam int unsigned R_W     = 4;
  localparam int unsigned OUT_W   = 7;
  localparam int          LAT     = Q_W + 1;
  localparam int          TMO     = 50;

  logic clk;
  logic rst;
  logic busy;
  int   checks;
  int   errors;

  mul12_recompose_if #(.Q_W(Q_W), .R_W(R_W), .OUT_W(OUT_W)) bus ();

  mul12_recompose #(
    .DIVISOR(DIVISOR),
    .Q_W    (Q_W),
    .R_W    (R_W),
    .OUT_W  (OUT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: plain arithmetic modulo 2**OUT_W, error on out-of-range remainder.
  function automatic longint model_data(input int q, input int r);
    return longint'((q * DIVISOR + r) % (1 << OUT_W));
  endfunction

  function automatic longint model_err(input int r);
    return (r >= DIVISOR) ? 1 : 0;
  endfunction

  // One full transaction; called at a negedge, returns at a negedge in IDLE.
  // hold = cycles to keep out_ready low in DONE while junk operands are offered.
  task automatic run_op(input int q, input int r, input int hold, input string tag);
    int n;
    longint ed;
    longint ee;
    ed = model_data(q, r);
    ee = model_err(r);
    bus.in_quot   = Q_W'(q);
    bus.in_rem    = R_W'(r);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    n = 0;
    while (!bus.in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (n >= TMO) check({tag, "_ready_timeout"}, n, 0);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    while (!bus.out_valid && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, LAT);
    for (int i = 0; i < hold; i++) begin
      check({tag, "_hold_data"}, bus.out_data, ed);
      check({tag, "_hold_inrdy"}, bus.in_ready, 0);
      bus.in_valid = 1'b1;
      bus.in_quot  = Q_W'($urandom);
      bus.in_rem   = R_W'($urandom);
      @(negedge clk);
    end
    check({tag, "_data"}, bus.out_data, ed);
    check({tag, "_err"}, bus.out_err, ee);
    check({tag, "_busy"}, busy, 1);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b0;
    check({tag, "_vld_drop"}, bus.out_valid, 0);
    check({tag, "_idle_rdy"}, bus.in_ready, 1);
  endtask

  initial begin
    int q;
    int r;
    int seen;
    checks        = 0;
    errors        = 0;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_quot   = '0;
    bus.in_rem    = '0;
    bus.out_ready = 1'b0;

    // Reset held three cycles, with junk on the inputs.
    repeat (3) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
    end
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_err", bus.out_err, 0);
    check("rst_busy", busy, 0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    rst           = 1'b0;
    @(negedge clk);
    check("idle_stays", busy, 0);

    // Basic directed operation.
    run_op(5, 7, 0, "q5r7");

    // Full legal sweep.
    for (int qi = 0; qi < (1 << Q_W); qi++) begin
      for (int ri = 0; ri < int'(DIVISOR); ri++) begin
        run_op(qi, ri, 0, "sweep");
      end
    end

    // Out-of-range remainder, then a clean op clears the error flag.
    run_op(7, 14, 0, "q7r14");
    run_op(1, 0, 0, "q1r0");

    // Backpressure in DONE with in_valid high and changing operands.
    run_op(3, 9, 10, "stall");
    run_op(4, 2, 0, "after_stall");

    // Randomized operands (including illegal remainders) and stall lengths.
    for (int k = 0; k < 40; k++) begin
      q = int'($urandom_range((1 << Q_W) - 1, 0));
      r = int'($urandom_range((1 << R_W) - 1, 0));
      run_op(q, r, int'($urandom_range(3, 0)), "rand");
    end

    // Reset in the middle of CALC discards the result.
    bus.in_quot  = Q_W'(6);
    bus.in_rem   = R_W'(3);
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("midcalc_busy", busy, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 1);
    check("midrst_out_valid", bus.out_valid, 0);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    check("midrst_no_pulse", seen, 0);
    run_op(2, 1, 0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
